rom_arbiter: RTL and testbench

ROM_ARBITER -- requirements
Module: rom_arbiter

---
 rtl/rom_arbiter.sv | 99 +++++++++
 tb/tb_rom_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/rom_arbiter.sv
// Two-requester round-robin arbiter in front of a registered-output ROM.
// Each read is ISSUE -> WAIT -> RESP; the next one can start straight from RESP.
module rom_arbiter #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t             state_q, state_d;
    logic               ptr_q, ptr_d;
    logic               sel_q, sel_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  rdata0_q, rdata0_d;
    logic [DATA_W-1:0]  rdata1_q, rdata1_d;
    logic               pick1;
    logic               any_req;

    // Requester 1 wins when alone, or on a tie when the pointer favours it.
    assign pick1   = req1 & (~req0 | ptr_q);
    assign any_req = req0 | req1;

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        sel_d    = sel_q;
        addr_d   = addr_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        case (state_q)
            IDLE, RESP: begin
                if (any_req) begin
                    state_d = ISSUE;
                    sel_d   = pick1;
                    addr_d  = pick1 ? addr1 : addr0;
                    ptr_d   = ~pick1;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                state_d = RESP;
                if (sel_q) rdata1_d = rom_data;
                else       rdata0_d = rom_data;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            ptr_q    <= 1'b0;
            sel_q    <= 1'b0;
            addr_q   <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            sel_q    <= sel_d;
            addr_q   <= addr_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    assign rom_en   = (state_q == ISSUE);
    assign rom_addr = addr_q;
    assign gnt0     = rom_en & ~sel_q;
    assign gnt1     = rom_en & sel_q;
    assign rvalid0  = (state_q == RESP) & ~sel_q;
    assign rvalid1  = (state_q == RESP) & sel_q;
    assign rdata0   = rdata0_q;
    assign rdata1   = rdata1_q;

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter with a registered 8x8 ROM model.
module tb_rom_arbiter;

    logic       clk = 1'b0;
    logic       rstn;
    logic       req0, req1;
    logic [2:0] addr0, addr1;
    logic       gnt0, gnt1, rvalid0, rvalid1;
    logic [7:0] rdata0, rdata1;
    logic       rom_en;
    logic [2:0] rom_addr;
    logic [7:0] rom_data = 8'h00;

    logic [7:0] rom [8] = '{8'h3C, 8'hA5, 8'h17, 8'hE2,
                            8'h5B, 8'hC9, 8'h70, 8'h8E};

    int n_cmp = 0;
    int n_err = 0;

    rom_arbiter #(.ADDR_W(3), .DATA_W(8)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .req0     (req0),
        .req1     (req1),
        .addr0    (addr0),
        .addr1    (addr1),
        .gnt0     (gnt0),
        .gnt1     (gnt1),
        .rvalid0  (rvalid0),
        .rvalid1  (rvalid1),
        .rdata0   (rdata0),
        .rdata1   (rdata1),
        .rom_en   (rom_en),
        .rom_addr (rom_addr),
        .rom_data (rom_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rom_en) rom_data <= rom[rom_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_outs(input string tag);
        chk({tag, "_gnt0"}, gnt0, 0);
        chk({tag, "_gnt1"}, gnt1, 0);
        chk({tag, "_rvalid0"}, rvalid0, 0);
        chk({tag, "_rvalid1"}, rvalid1, 0);
        chk({tag, "_rom_en"}, rom_en, 0);
    endtask

    initial begin
        rstn  = 1'b0;
        req0  = 1'b1;
        req1  = 1'b0;
        addr0 = 3'd2;
        addr1 = 3'd0;
        #12;
        chk_idle_outs("rst");
        chk("rst_rdata0", rdata0, 0);
        chk("rst_rdata1", rdata1, 0);
        chk("rst_rom_addr", rom_addr, 0);
        step();
        rstn = 1'b1;
        step();
        chk("rel_gnt0", gnt0, 1);
        chk("rel_rom_addr", rom_addr, 2);
        req0 = 1'b0;
        step();
        step();
        chk("rel_rvalid0", rvalid0, 1);
        chk("rel_rdata0", rdata0, rom[2]);
        step();

        req0  = 1'b1;
        addr0 = 3'b011;
        step();
        chk("sgl_gnt0", gnt0, 1);
        chk("sgl_gnt1", gnt1, 0);
        chk("sgl_rom_en", rom_en, 1);
        chk("sgl_rom_addr", rom_addr, 3);
        req0  = 1'b0;
        addr0 = 3'd7;
        step();
        chk_idle_outs("sgl_wait");
        chk("sgl_wait_addr", rom_addr, 3);
        step();
        chk("sgl_rvalid0", rvalid0, 1);
        chk("sgl_rvalid1", rvalid1, 0);
        chk("sgl_resp_gnt0", gnt0, 0);
        chk("sgl_rdata0", rdata0, rom[3]);
        step();
        chk("sgl_idle_rvalid0", rvalid0, 0);
        chk("sgl_hold_rdata0", rdata0, rom[3]);
        chk("sgl_hold_addr", rom_addr, 3);

        rstn  = 1'b0;
        req0  = 1'b1;
        req1  = 1'b1;
        addr0 = 3'd1;
        addr1 = 3'd5;
        #1;
        chk("con_async_rdata0", rdata0, 0);
        chk("con_async_addr", rom_addr, 0);
        step();
        rstn = 1'b1;
        step();
        chk("con_gnt0", gnt0, 1);
        chk("con_gnt1", gnt1, 0);
        chk("con_addr0", rom_addr, 1);
        req0 = 1'b0;
        step();
        step();
        chk("con_rvalid0", rvalid0, 1);
        chk("con_rdata0", rdata0, rom[1]);
        chk("con_resp_gnt1", gnt1, 0);
        step();
        chk("con_gnt1_next", gnt1, 1);
        chk("con_addr1", rom_addr, 5);
        chk("con_rvalid0_off", rvalid0, 0);
        req1 = 1'b0;
        step();
        step();
        chk("con_rvalid1", rvalid1, 1);
        chk("con_rdata1", rdata1, rom[5]);
        chk("con_rdata0_keep", rdata0, rom[1]);
        step();

        req0  = 1'b1;
        req1  = 1'b1;
        addr0 = 3'd6;
        addr1 = 3'd4;
        for (int c = 0; c < 18; c++) begin
            step();
            chk($sformatf("fair%0d_gnt0", c), gnt0,
                32'((c % 3 == 0) && ((c / 3) % 2 == 0)));
            chk($sformatf("fair%0d_gnt1", c), gnt1,
                32'((c % 3 == 0) && ((c / 3) % 2 == 1)));
            chk($sformatf("fair%0d_rv0", c), rvalid0,
                32'((c % 3 == 2) && ((c / 3) % 2 == 0)));
            chk($sformatf("fair%0d_rv1", c), rvalid1,
                32'((c % 3 == 2) && ((c / 3) % 2 == 1)));
        end
        req0 = 1'b0;
        req1 = 1'b0;
        step();
        chk_idle_outs("fair_end");
        chk("fair_rdata0", rdata0, rom[6]);
        chk("fair_rdata1", rdata1, rom[4]);

        for (int a = 0; a < 8; a++) begin
            req1  = 1'b1;
            addr1 = a[2:0];
            step();
            chk($sformatf("swp%0d_gnt1", a), gnt1, 1);
            chk($sformatf("swp%0d_addr", a), rom_addr, a);
            req1 = 1'b0;
            step();
            step();
            chk($sformatf("swp%0d_rv1", a), rvalid1, 1);
            chk($sformatf("swp%0d_rdata1", a), rdata1, rom[a]);
            chk($sformatf("swp%0d_rdata0", a), rdata0, rom[6]);
            step();
        end

        req0  = 1'b1;
        addr0 = 3'd3;
        step();
        chk("mid_gnt0", gnt0, 1);
        req0 = 1'b0;
        step();
        chk("mid_wait_en", rom_en, 0);
        rstn = 1'b0;
        #1;
        chk("mid_rdata0", rdata0, 0);
        chk("mid_rom_addr", rom_addr, 0);
        step();
        step();
        rstn = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            chk_idle_outs($sformatf("mid_quiet%0d", c));
        end
        chk("mid_rdata0_after", rdata0, 0);
        req0  = 1'b1;
        req1  = 1'b1;
        addr0 = 3'd2;
        addr1 = 3'd3;
        step();
        chk("mid_ptr_gnt0", gnt0, 1);
        chk("mid_ptr_gnt1", gnt1, 0);
        chk("mid_ptr_addr", rom_addr, 2);
        req0 = 1'b0;
        req1 = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
